// File: rtl/sobolflex_ctrl.sv
// sobolflex_ctrl: sequencing controller for the sobolflex Sobol RNG core.
// Keeps one index counter per core state channel and turns the selected
// channel's index into a lowest-zero-bit one-hot that picks the direction
// vector the core XORs into its state. Runs are length-bounded and use a
// start/done handshake.
//
// Optional feature macro: SOBOLFLEX_CTRL_WRAP_EN
//   When defined, adds output oWrap, which flags the step taken at the
//   all-ones index. That step also ends the run.

module sobolflex_ctrl #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iChan,
  input  logic                iFresh,
  input  logic [BITWIDTH:0]   iLen,
  input  logic                iHold,
  output logic [BITWIDTH-1:0] oOneHot,
  output logic                oSel,
  output logic                oClr,
  output logic                oEn,
  output logic [BITWIDTH-1:0] oIdx,
  output logic                oBusy,
`ifdef SOBOLFLEX_CTRL_WRAP_EN
  output logic                oWrap,
`endif
  output logic                oDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [BITWIDTH:0]   LEN_ONE = {{BITWIDTH{1'b0}}, 1'b1};
  localparam logic [BITWIDTH-1:0] IDX_ONE = {{(BITWIDTH-1){1'b0}}, 1'b1};

  state_t              state_reg;
  state_t              state_next;
  logic                chan_reg;
  logic [BITWIDTH:0]   remaining_reg;

  logic [BITWIDTH-1:0] cnt_sel;
  logic [BITWIDTH-1:0] cnt_inc;
  logic                step;
  logic                is_ones;
  logic                last_step;
  logic                accept;

  // A step happens on every non-stalled RUN cycle.
  assign step    = (state_reg == RUN) && !iHold;
  assign accept  = (state_reg == IDLE) && iStart;
  assign is_ones = &cnt_sel;
  assign cnt_inc = cnt_sel + IDX_ONE;

`ifdef SOBOLFLEX_CTRL_WRAP_EN
  // The all-ones step ends the run early so the index never wraps inside a run.
  assign last_step = step && ((remaining_reg == LEN_ONE) || is_ones);
`else
  assign last_step = step && (remaining_reg == LEN_ONE);
`endif

  // One index counter per core channel. CLEAR wipes both, because the core
  // clears both of its state registers at once.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [BITWIDTH-1:0] cnt;
      logic                mine;
      assign mine = (chan_reg == (gi == 1));

      // Channel counter: clear on CLEAR, advance only on steps of this channel.
      always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
          cnt <= '0;
        end else if (state_reg == CLEAR) begin
          cnt <= '0;
        end else if (step && mine) begin
          cnt <= cnt_inc;
        end
      end
    end
  endgenerate

  assign cnt_sel = chan_reg ? g_cnt[1].cnt : g_cnt[0].cnt;

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Run parameters: latched on an accepted start, remaining counts down per step.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      chan_reg      <= 1'b0;
      remaining_reg <= '0;
    end else if (accept) begin
      chan_reg      <= iChan;
      remaining_reg <= iLen;
    end else if (step) begin
      remaining_reg <= remaining_reg - LEN_ONE;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (iStart) begin
          if (iLen == '0) begin
            state_next = DONE;
          end else if (iFresh) begin
            state_next = CLEAR;
          end else begin
            state_next = RUN;
          end
        end
      end
      CLEAR:   state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from registered state and the stall input.
  always_comb begin
    oOneHot = '0;
    oEn     = step;
    oClr    = (state_reg == CLEAR);
    oBusy   = (state_reg == CLEAR) || (state_reg == RUN);
    oDone   = (state_reg == DONE);
    oSel    = chan_reg;
    oIdx    = cnt_sel;
    // Lowest zero bit of the index; all-ones yields zero (no direction vector).
    if (step) begin
      oOneHot = ~cnt_sel & cnt_inc;
    end
`ifdef SOBOLFLEX_CTRL_WRAP_EN
    oWrap   = step && is_ones;
`endif
  end

endmodule

// File: tb/tb_sobolflex_ctrl.sv
// Testbench for sobolflex_ctrl: expected steps are queued when a run is
// launched and compared as the DUT asserts oEn.
`timescale 1ns/1ps

module tb_sobolflex_ctrl;

  logic       iClk;
  logic       iRstN;
  logic       iStart;
  logic       iChan;
  logic       iFresh;
  logic [8:0] iLen;
  logic       iHold;
  logic [7:0] oOneHot;
  logic       oSel;
  logic       oClr;
  logic       oEn;
  logic [7:0] oIdx;
  logic       oBusy;
  logic       oDone;
`ifdef SOBOLFLEX_CTRL_WRAP_EN
  logic       oWrap;
`endif

  sobolflex_ctrl #(.BITWIDTH(8)) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iStart  (iStart),
    .iChan   (iChan),
    .iFresh  (iFresh),
    .iLen    (iLen),
    .iHold   (iHold),
    .oOneHot (oOneHot),
    .oSel    (oSel),
    .oClr    (oClr),
    .oEn     (oEn),
    .oIdx    (oIdx),
    .oBusy   (oBusy),
`ifdef SOBOLFLEX_CTRL_WRAP_EN
    .oWrap   (oWrap),
`endif
    .oDone   (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0] oh;
    logic [7:0] idx;
    logic       sel;
    logic       wrap;
  } step_t;

  step_t q[$];
  logic [7:0] mcnt [2];
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Lowest zero bit of v as a one-hot, zero when v is all ones.
  function automatic logic [7:0] lzo(input logic [7:0] v);
    lzo = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      if (!v[b]) lzo = 8'h01 << b;
    end
  endfunction

  // Queue the steps a run of len on channel ch should produce; returns count.
  function automatic int push_steps(input logic ch, input int len);
    int n = 0;
    for (int k = 0; k < len; k++) begin
      step_t s;
      s.oh   = lzo(mcnt[ch]);
      s.idx  = mcnt[ch];
      s.sel  = ch;
      s.wrap = (mcnt[ch] == 8'hff);
      q.push_back(s);
      n++;
      mcnt[ch] = mcnt[ch] + 8'd1;
`ifdef SOBOLFLEX_CTRL_WRAP_EN
      if (s.wrap) break;
`endif
    end
    return n;
  endfunction

  // Step monitor: compare each performed step against the scoreboard.
  always @(negedge iClk) begin
    if (iRstN && oEn) begin
      if (q.size() == 0) begin
        chk("extra_step", 32'd1, 32'd0);
      end else begin
        step_t e;
        e = q.pop_front();
        chk("onehot", {24'd0, oOneHot}, {24'd0, e.oh});
        chk("step_idx", {24'd0, oIdx}, {24'd0, e.idx});
        chk("step_sel", {31'd0, oSel}, {31'd0, e.sel});
`ifdef SOBOLFLEX_CTRL_WRAP_EN
        chk("wrap", {31'd0, oWrap}, {31'd0, e.wrap});
`endif
      end
      $display("step idx=%0h onehot=%0h sel=%0b", oIdx, oOneHot, oSel);
    end
    if (iRstN && oDone) done_cnt++;
  end

  task automatic run(input logic ch, input logic fr, input int len, input int nhold, input bit poke);
    int  npush;
    int  cyc;
    int  steps;
    int  held;
    int  exp_lat;
    int  d0;
    bit  fresh_eff;
    logic [7:0] exp_idx;
    fresh_eff = fr && (len != 0);
    if (fresh_eff) begin
      mcnt[0] = 8'd0;
      mcnt[1] = 8'd0;
    end
    npush   = push_steps(ch, len);
    exp_idx = mcnt[ch];
    exp_lat = int'(fresh_eff) + npush + nhold + 1;
    d0      = done_cnt;
    @(posedge iClk); #1;
    iStart = 1'b1; iChan = ch; iFresh = fr; iLen = len[8:0];
    @(posedge iClk); #1;
    iStart = 1'b0;
    cyc = 0; steps = 0; held = 0;
    while (1) begin
      @(negedge iClk);
      cyc++;
      if (cyc == 1) begin
        chk("clr", {31'd0, oClr}, {31'd0, fresh_eff});
        if (fresh_eff) chk("clr_sel", {31'd0, oSel}, {31'd0, ch});
      end
      if (iHold) begin
        chk("hold_en", {31'd0, oEn}, 32'd0);
        chk("hold_onehot", {24'd0, oOneHot}, 32'd0);
        held++;
      end
      if (oEn) steps++;
      if (oDone) break;
      if (cyc > exp_lat + 20) begin
        chk("timeout", 32'd0, 32'd1);
        q.delete();
        break;
      end
      @(posedge iClk); #1;
      iHold  = (steps == 1 && held < nhold);
      iStart = 1'b0;
      if (poke && cyc == 3) begin
        iStart = 1'b1; iChan = ~ch; iFresh = 1'b1; iLen = 9'd5;
      end
    end
    iHold = 1'b0; iStart = 1'b0;
    $display("run ch=%0b fresh=%0b len=%0d hold=%0d: done after %0d cycles, steps=%0d, idx=%0h",
             ch, fr, len, nhold, cyc, steps, oIdx);
    chk("latency", cyc, exp_lat);
    chk("steps", steps, npush);
    chk("done_idx", {24'd0, oIdx}, {24'd0, exp_idx});
    chk("done_busy", {31'd0, oBusy}, 32'd0);
    chk("q_left", q.size(), 32'd0);
    repeat (3) begin
      @(negedge iClk);
      chk("idle_busy", {31'd0, oBusy}, 32'd0);
      chk("idle_sel", {31'd0, oSel}, {31'd0, ch});
    end
    chk("done_pulses", done_cnt - d0, 32'd1);
  endtask

  initial begin
    int d0;
    int np;
    iRstN = 1'b0; iStart = 1'b0; iChan = 1'b0; iFresh = 1'b0; iLen = 9'd0; iHold = 1'b0;
    mcnt[0] = 8'd0; mcnt[1] = 8'd0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_done", {31'd0, oDone}, 32'd0);
    #1 iRstN = 1'b1;

    // Idle after reset: everything quiet.
    repeat (5) begin
      @(negedge iClk);
      chk("idle_onehot", {24'd0, oOneHot}, 32'd0);
      chk("idle_sel0", {31'd0, oSel}, 32'd0);
      chk("idle_clr", {31'd0, oClr}, 32'd0);
      chk("idle_busy0", {31'd0, oBusy}, 32'd0);
      chk("idle_done", {31'd0, oDone}, 32'd0);
      chk("idle_idx", {24'd0, oIdx}, 32'd0);
    end

    // Fresh run of 4 on channel 0: 01,02,01,04.
    run(1'b0, 1'b1, 4, 0, 1'b0);
    // Interleaved channels keep separate indices.
    run(1'b1, 1'b0, 2, 0, 1'b0);
    run(1'b0, 1'b0, 2, 0, 1'b0);
    run(1'b1, 1'b0, 0, 0, 1'b0);
    // Stall two cycles after the first step.
    run(1'b0, 1'b1, 3, 2, 1'b0);
    // Zero length, even with fresh set, does no clear and no step.
    run(1'b1, 1'b1, 0, 0, 1'b0);
    // Start pulse while running is ignored.
    run(1'b0, 1'b0, 10, 0, 1'b1);
    // Index wrap.
`ifdef SOBOLFLEX_CTRL_WRAP_EN
    run(1'b0, 1'b1, 300, 0, 1'b0);
`else
    run(1'b0, 1'b1, 256, 0, 1'b0);
`endif

    // Reset in the middle of a run on channel 1.
    np = push_steps(1'b1, 20);
    @(posedge iClk); #1;
    iStart = 1'b1; iChan = 1'b1; iFresh = 1'b0; iLen = 9'd20;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (4) @(posedge iClk);
    #2 iRstN = 1'b0;
    #1;
    $display("reset mid-run (%0d steps queued)", np);
    chk("mrst_onehot", {24'd0, oOneHot}, 32'd0);
    chk("mrst_en", {31'd0, oEn}, 32'd0);
    chk("mrst_busy", {31'd0, oBusy}, 32'd0);
    chk("mrst_done", {31'd0, oDone}, 32'd0);
    chk("mrst_sel", {31'd0, oSel}, 32'd0);
    chk("mrst_clr", {31'd0, oClr}, 32'd0);
    chk("mrst_idx", {24'd0, oIdx}, 32'd0);
    q.delete();
    mcnt[0] = 8'd0; mcnt[1] = 8'd0;
    d0 = done_cnt;
    @(negedge iClk);
    #1 iRstN = 1'b1;
    repeat (3) begin
      @(negedge iClk);
      chk("post_rst_busy", {31'd0, oBusy}, 32'd0);
    end
    chk("post_rst_nodone", done_cnt - d0, 32'd0);
    run(1'b1, 1'b0, 0, 0, 1'b0);
    run(1'b0, 1'b0, 0, 0, 1'b0);
    run(1'b1, 1'b0, 3, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
